instruction_dispatcher: RTL and testbench



---
 rtl/dispatch_pkg.sv | 34 +++
 rtl/dispatch_decode.sv | 71 +++++++
 rtl/instruction_dispatcher.sv | 142 ++++++++++++++
 tb/tb_instruction_dispatcher.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dispatch_pkg.sv
// Shared definitions for the dual-issue instruction dispatcher:
// RV32I opcodes, instruction classes and the decoded-fields bundle.
package dispatch_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        CLS_ALU    = 2'd0,
        CLS_MEM    = 2'd1,
        CLS_CTRL   = 2'd2,
        CLS_SERIAL = 2'd3
    } instr_class_e;

    typedef struct packed {
        logic [4:0]   rs1;
        logic [4:0]   rs2;
        logic [4:0]   rd;
        logic         uses_rs1;
        logic         uses_rs2;
        logic         writes_rd;
        instr_class_e cls;
    } decoded_t;

endpackage

// File: rtl/dispatch_decode.sv
// Combinational RV32I classifier for one buffer entry.
// Ports: opcode/rd/rs1/rs2 fields in, decoded bundle (dec) out.
module dispatch_decode
    import dispatch_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [4:0] rd,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    output decoded_t   dec
);

    logic writes;

    always_comb begin
        dec          = '0;
        dec.rs1      = rs1;
        dec.rs2      = rs2;
        dec.rd       = rd;
        dec.cls      = CLS_SERIAL;
        writes       = 1'b0;
        unique case (opcode)
            OPC_OP: begin
                dec.cls      = CLS_ALU;
                dec.uses_rs1 = 1'b1;
                dec.uses_rs2 = 1'b1;
                writes       = 1'b1;
            end
            OPC_OP_IMM: begin
                dec.cls      = CLS_ALU;
                dec.uses_rs1 = 1'b1;
                writes       = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                dec.cls      = CLS_ALU;
                writes       = 1'b1;
            end
            OPC_LOAD: begin
                dec.cls      = CLS_MEM;
                dec.uses_rs1 = 1'b1;
                writes       = 1'b1;
            end
            OPC_STORE: begin
                dec.cls      = CLS_MEM;
                dec.uses_rs1 = 1'b1;
                dec.uses_rs2 = 1'b1;
            end
            OPC_BRANCH: begin
                dec.cls      = CLS_CTRL;
                dec.uses_rs1 = 1'b1;
                dec.uses_rs2 = 1'b1;
            end
            OPC_JAL: begin
                dec.cls      = CLS_CTRL;
                writes       = 1'b1;
            end
            OPC_JALR: begin
                dec.cls      = CLS_CTRL;
                dec.uses_rs1 = 1'b1;
                writes       = 1'b1;
            end
            default: begin
                // SYSTEM, FENCE and unknown opcodes: serialising, no rd
                dec.cls      = CLS_SERIAL;
            end
        endcase
        // x0 is hardwired, so a write to it never creates a hazard
        dec.writes_rd = writes & (rd != 5'd0);
    end

endmodule

// File: rtl/instruction_dispatcher.sv
// Dual in-order issue from the instruction buffer head into two registered
// slots (lane 0 full, lane 1 ALU-only), guarded by a RAW/WAW scoreboard.
// Ports: clk/rst, flush; entry0/1 instruction+address and entry_count in;
// pop0/pop1 out (combinational); issueN_valid/instruction/address out with
// issueN_ready in; wbN_valid/wbN_rd in clear scoreboard bits.
module instruction_dispatcher
    import dispatch_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [XLEN-1:0] entry0_instruction,
    input  logic [XLEN-1:0] entry0_address,
    input  logic [XLEN-1:0] entry1_instruction,
    input  logic [XLEN-1:0] entry1_address,
    input  logic [3:0]      entry_count,
    output logic            pop0,
    output logic            pop1,
    output logic            issue0_valid,
    output logic [XLEN-1:0] issue0_instruction,
    output logic [XLEN-1:0] issue0_address,
    input  logic            issue0_ready,
    output logic            issue1_valid,
    output logic [XLEN-1:0] issue1_instruction,
    output logic [XLEN-1:0] issue1_address,
    input  logic            issue1_ready,
    input  logic            wb0_valid,
    input  logic [4:0]      wb0_rd,
    input  logic            wb1_valid,
    input  logic [4:0]      wb1_rd
);

    decoded_t            d0;
    decoded_t            d1;
    logic [NUM_REGS-1:0] sb;
    logic [NUM_REGS-1:0] sb_next;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;
    logic                free0;
    logic                free1;
    logic                hit0;
    logic                hit1;
    logic                dep1;
    logic                serial_ok0;
    logic                pair_ok;

    dispatch_decode u_dec0 (
        .opcode (entry0_instruction[6:0]),
        .rd     (entry0_instruction[11:7]),
        .rs1    (entry0_instruction[19:15]),
        .rs2    (entry0_instruction[24:20]),
        .dec    (d0)
    );

    dispatch_decode u_dec1 (
        .opcode (entry1_instruction[6:0]),
        .rd     (entry1_instruction[11:7]),
        .rs1    (entry1_instruction[19:15]),
        .rs2    (entry1_instruction[24:20]),
        .dec    (d1)
    );

    assign free0 = !issue0_valid || issue0_ready;
    assign free1 = !issue1_valid || issue1_ready;

    assign hit0 = (d0.uses_rs1  && sb[d0.rs1])
               || (d0.uses_rs2  && sb[d0.rs2])
               || (d0.writes_rd && sb[d0.rd]);

    assign hit1 = (d1.uses_rs1  && sb[d1.rs1])
               || (d1.uses_rs2  && sb[d1.rs2])
               || (d1.writes_rd && sb[d1.rd]);

    // Intra-pair RAW/WAW on the register entry0 is about to claim
    assign dep1 = d0.writes_rd
               && ((d1.uses_rs1  && d1.rs1 == d0.rd)
                || (d1.uses_rs2  && d1.rs2 == d0.rd)
                || (d1.writes_rd && d1.rd  == d0.rd));

    // Serialising ops wait for a fully drained pipeline
    assign serial_ok0 = (d0.cls != CLS_SERIAL)
                     || (sb == '0 && !issue0_valid && !issue1_valid);

    assign pair_ok = (d0.cls == CLS_ALU || d0.cls == CLS_MEM)
                  && (d1.cls == CLS_ALU);

    assign pop0 = !rst && !flush
               && (entry_count >= 4'd1)
               && free0 && !hit0 && serial_ok0;

    assign pop1 = pop0
               && (entry_count >= 4'd2)
               && free1 && pair_ok && !hit1 && !dep1;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (pop0 && d0.writes_rd) set_mask[d0.rd] = 1'b1;
        if (pop1 && d1.writes_rd) set_mask[d1.rd] = 1'b1;
        if (wb0_valid)            clr_mask[wb0_rd] = 1'b1;
        if (wb1_valid)            clr_mask[wb1_rd] = 1'b1;
        // Set after clear so a same-cycle reissue keeps the bit busy
        sb_next    = (sb & ~clr_mask) | set_mask;
        sb_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb                 <= '0;
            issue0_valid       <= 1'b0;
            issue0_instruction <= '0;
            issue0_address     <= '0;
            issue1_valid       <= 1'b0;
            issue1_instruction <= '0;
            issue1_address     <= '0;
        end else if (flush) begin
            sb           <= '0;
            issue0_valid <= 1'b0;
            issue1_valid <= 1'b0;
        end else begin
            sb <= sb_next;
            if (pop0) begin
                issue0_valid       <= 1'b1;
                issue0_instruction <= entry0_instruction;
                issue0_address     <= entry0_address;
            end else if (issue0_ready) begin
                issue0_valid       <= 1'b0;
            end
            if (pop1) begin
                issue1_valid       <= 1'b1;
                issue1_instruction <= entry1_instruction;
                issue1_address     <= entry1_address;
            end else if (issue1_ready) begin
                issue1_valid       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instruction_dispatcher.sv
// Directed, table-driven bench for instruction_dispatcher plus a hand-written
// stall/flush sequence; expected values are hand-computed constants.
module tb_instruction_dispatcher;

    localparam logic [31:0] ADDI1  = 32'h00500093; // addi x1,x0,5
    localparam logic [31:0] ADDI3  = 32'h00700193; // addi x3,x0,7
    localparam logic [31:0] ADD211 = 32'h00108133; // add x2,x1,x1
    localparam logic [31:0] BEQ    = 32'h00000463; // beq x0,x0,8
    localparam logic [31:0] LW4    = 32'h00002203; // lw x4,0(x0)
    localparam logic [31:0] RD_X3  = 32'h00018293; // addi x5,x3,0
    localparam logic [31:0] RD_X1  = 32'h00008313; // addi x6,x1,0
    localparam logic [31:0] WR_X6  = 32'h00100313; // addi x6,x0,1
    localparam logic [31:0] NOP    = 32'h00000013; // addi x0,x0,0
    localparam logic [31:0] ECALL  = 32'h00000073;
    localparam logic [31:0] FENCE  = 32'h0000000f;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] entry0_instruction;
    logic [31:0] entry0_address;
    logic [31:0] entry1_instruction;
    logic [31:0] entry1_address;
    logic [3:0]  entry_count;
    logic        pop0;
    logic        pop1;
    logic        issue0_valid;
    logic [31:0] issue0_instruction;
    logic [31:0] issue0_address;
    logic        issue0_ready;
    logic        issue1_valid;
    logic [31:0] issue1_instruction;
    logic [31:0] issue1_address;
    logic        issue1_ready;
    logic        wb0_valid;
    logic [4:0]  wb0_rd;
    logic        wb1_valid;
    logic [4:0]  wb1_rd;

    int errors = 0;
    int checks = 0;

    instruction_dispatcher dut (
        .clk                (clk),
        .rst                (rst),
        .flush              (flush),
        .entry0_instruction (entry0_instruction),
        .entry0_address     (entry0_address),
        .entry1_instruction (entry1_instruction),
        .entry1_address     (entry1_address),
        .entry_count        (entry_count),
        .pop0               (pop0),
        .pop1               (pop1),
        .issue0_valid       (issue0_valid),
        .issue0_instruction (issue0_instruction),
        .issue0_address     (issue0_address),
        .issue0_ready       (issue0_ready),
        .issue1_valid       (issue1_valid),
        .issue1_instruction (issue1_instruction),
        .issue1_address     (issue1_address),
        .issue1_ready       (issue1_ready),
        .wb0_valid          (wb0_valid),
        .wb0_rd             (wb0_rd),
        .wb1_valid          (wb1_valid),
        .wb1_rd             (wb1_rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  cnt;
        logic [31:0] e0;
        logic [31:0] e1;
        logic        fl;
        logic        w0v;
        logic [4:0]  w0rd;
        logic        w1v;
        logic [4:0]  w1rd;
        logic        p0;
        logic        p1;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [3:0] cnt,
                       input logic [31:0] e0, e1,
                       input logic fl, w0v, input logic [4:0] w0rd,
                       input logic w1v, input logic [4:0] w1rd,
                       input logic p0, p1);
        vec_t v;
        v.cnt = cnt; v.e0 = e0; v.e1 = e1; v.fl = fl;
        v.w0v = w0v; v.w0rd = w0rd; v.w1v = w1v; v.w1rd = w1rd;
        v.p0 = p0; v.p1 = p1;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] c,
                         input logic [31:0] i0, ad0, i1, ad1,
                         input logic f, r0, r1, wv0, input logic [4:0] wr0,
                         input logic wv1, input logic [4:0] wr1);
        entry_count        = c;
        entry0_instruction = i0;
        entry0_address     = ad0;
        entry1_instruction = i1;
        entry1_address     = ad1;
        flush              = f;
        issue0_ready       = r0;
        issue1_ready       = r1;
        wb0_valid          = wv0;
        wb0_rd             = wr0;
        wb1_valid          = wv1;
        wb1_rd             = wr1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] a0;
        logic [31:0] a1;

        //   cnt e0      e1     fl w0v rd w1v rd p0 p1
        add(2, ADDI1,  ADDI3, 0, 0, 0, 0, 0, 1, 1);
        add(2, RD_X3,  NOP,   0, 0, 0, 0, 0, 0, 0);
        add(1, RD_X1,  NOP,   0, 1, 3, 0, 0, 0, 0);
        add(1, RD_X3,  NOP,   0, 0, 0, 1, 1, 1, 0);
        add(2, RD_X1,  NOP,   0, 0, 0, 0, 0, 1, 1);
        add(2, ADDI1,  ADDI3, 1, 1, 5, 0, 0, 0, 0);
        add(2, ADDI1,  ADD211,0, 0, 0, 0, 0, 1, 0);
        add(1, ADD211, NOP,   0, 0, 0, 0, 0, 0, 0);
        add(1, ADD211, NOP,   0, 1, 1, 0, 0, 0, 0);
        add(1, ADD211, NOP,   0, 0, 0, 0, 0, 1, 0);
        add(0, NOP,    NOP,   1, 0, 0, 0, 0, 0, 0);
        add(2, BEQ,    ADDI3, 0, 0, 0, 0, 0, 1, 0);
        add(1, ADDI3,  NOP,   0, 0, 0, 0, 0, 1, 0);
        add(0, NOP,    NOP,   0, 1, 3, 0, 0, 0, 0);
        add(2, NOP,    LW4,   0, 0, 0, 0, 0, 1, 0);
        add(1, LW4,    NOP,   0, 0, 0, 0, 0, 1, 0);
        add(0, NOP,    NOP,   1, 0, 0, 0, 0, 0, 0);
        add(1, ADDI1,  NOP,   0, 1, 1, 0, 0, 1, 0);
        add(1, RD_X1,  NOP,   0, 0, 0, 0, 0, 0, 0);
        add(0, NOP,    NOP,   0, 1, 1, 1, 1, 0, 0);
        add(1, RD_X1,  NOP,   0, 0, 0, 0, 0, 1, 0);
        add(1, WR_X6,  NOP,   0, 0, 0, 0, 0, 0, 0);
        add(0, NOP,    NOP,   1, 0, 0, 0, 0, 0, 0);
        add(1, ECALL,  NOP,   0, 0, 0, 0, 0, 1, 0);
        add(1, ECALL,  NOP,   0, 0, 0, 0, 0, 0, 0);
        add(2, ECALL,  NOP,   0, 0, 0, 0, 0, 1, 0);
        add(1, ADDI3,  NOP,   0, 0, 0, 0, 0, 1, 0);
        add(0, NOP,    NOP,   0, 0, 0, 0, 0, 0, 0);
        add(1, FENCE,  NOP,   0, 0, 0, 0, 0, 0, 0);
        add(1, FENCE,  NOP,   0, 1, 3, 0, 0, 0, 0);
        add(1, FENCE,  NOP,   0, 0, 0, 0, 0, 1, 0);
        add(0, NOP,    NOP,   1, 0, 0, 0, 0, 0, 0);

        // Reset, with a poppable entry presented
        rst = 1'b1;
        drive(2, ADDI1, 32'h100, ADDI3, 32'h104, 0, 1, 1, 0, 0, 0, 0);
        tick();
        tick();
        chk("rst pop0", pop0, 0);
        chk("rst pop1", pop1, 0);
        chk("rst v0", issue0_valid, 0);
        chk("rst v1", issue1_valid, 0);
        chk("rst i0", issue0_instruction, 0);
        chk("rst a1", issue1_address, 0);
        rst = 1'b0;

        foreach (vq[i]) begin
            a0 = 32'h1000 + 32'(i) * 8;
            a1 = a0 + 4;
            drive(vq[i].cnt, vq[i].e0, a0, vq[i].e1, a1, vq[i].fl,
                  1, 1, vq[i].w0v, vq[i].w0rd, vq[i].w1v, vq[i].w1rd);
            #1;
            chk($sformatf("v%0d pop0", i), pop0, vq[i].p0);
            chk($sformatf("v%0d pop1", i), pop1, vq[i].p1);
            tick();
            chk($sformatf("v%0d valid0", i), issue0_valid, vq[i].p0);
            chk($sformatf("v%0d valid1", i), issue1_valid, vq[i].p1);
            if (vq[i].p0) begin
                chk($sformatf("v%0d instr0", i), issue0_instruction, vq[i].e0);
                chk($sformatf("v%0d addr0", i), issue0_address, a0);
            end
            if (vq[i].p1) begin
                chk($sformatf("v%0d instr1", i), issue1_instruction, vq[i].e1);
                chk($sformatf("v%0d addr1", i), issue1_address, a1);
            end
        end

        // Backpressure on both lanes, then flush during the stall
        drive(2, ADDI1, 32'h2000, ADDI3, 32'h2004, 0, 1, 1, 0, 0, 0, 0);
        #1;
        chk("stall pop0 first", pop0, 1);
        chk("stall pop1 first", pop1, 1);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(2, NOP, 32'h3000, NOP, 32'h3004, 0, 0, 0, 0, 0, 0, 0);
            #1;
            chk($sformatf("stall%0d pop0", k), pop0, 0);
            chk($sformatf("stall%0d pop1", k), pop1, 0);
            tick();
            chk($sformatf("stall%0d v0", k), issue0_valid, 1);
            chk($sformatf("stall%0d i0", k), issue0_instruction, ADDI1);
            chk($sformatf("stall%0d a0", k), issue0_address, 32'h2000);
            chk($sformatf("stall%0d v1", k), issue1_valid, 1);
            chk($sformatf("stall%0d i1", k), issue1_instruction, ADDI3);
        end
        drive(2, NOP, 32'h3000, NOP, 32'h3004, 1, 0, 0, 0, 0, 0, 0);
        #1;
        chk("flush pop0", pop0, 0);
        tick();
        chk("flush v0", issue0_valid, 0);
        chk("flush v1", issue1_valid, 0);
        // x1 and x3 were busy before the flush; both must now be free
        drive(2, RD_X1, 32'h4000, RD_X3, 32'h4004, 0, 1, 1, 0, 0, 0, 0);
        #1;
        chk("post-flush pop0", pop0, 1);
        chk("post-flush pop1", pop1, 1);
        tick();
        // Lane 1 stalled alone: lane 0 keeps issuing
        drive(2, NOP, 32'h5000, NOP, 32'h5004, 0, 1, 0, 0, 0, 0, 0);
        #1;
        chk("lane1 stall pop0", pop0, 1);
        chk("lane1 stall pop1", pop1, 0);
        tick();
        chk("lane1 stall i0", issue0_instruction, NOP);
        chk("lane1 stall v1", issue1_valid, 1);
        chk("lane1 stall i1", issue1_instruction, RD_X3);
        chk("lane1 stall a1", issue1_address, 32'h4004);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
